// File: rtl/cook_sequencer.sv
// cook_sequencer: microwave cook-cycle FSM with keypad entry, door interlock, power duty-cycle and beeper.
// Define COOK_SEQUENCER_QUICK_START_EN to make start in IDLE program and run a 0:30 cook.
module cook_sequencer #(
    parameter int BEEP_SECONDS = 3,
    parameter int MAX_DIGITS = 3,
    parameter int POWER_PERIOD = 10
) (
    input  logic       clk,
    input  logic       clear,
    input  logic       tick_1hz,
    input  logic       start,
    input  logic       stop,
    input  logic       closed_door,
    input  logic       key_valid,
    input  logic [3:0] key_code,
    input  logic       power_key,
    input  logic       timer_zero,
    output logic       timer_load,
    output logic [3:0] timer_data,
    output logic       timer_clear,
    output logic       timer_en,
    output logic       magnetron,
    output logic       beeper,
    output logic       lamp,
    output logic [3:0] power_level,
    output logic [2:0] state
);
    localparam int DW = $clog2(MAX_DIGITS + 1);
    localparam logic [DW-1:0] MAX_D = DW'(MAX_DIGITS);
    localparam logic [3:0] PP = 4'(POWER_PERIOD);
    localparam logic [3:0] BEEP = 4'(BEEP_SECONDS);
`ifdef COOK_SEQUENCER_QUICK_START_EN
    typedef enum logic [2:0] {IDLE = 3'd0, ENTRY = 3'd1, COOKING = 3'd2, PAUSED = 3'd3, DONE = 3'd4, QLOAD = 3'd5} state_t;
`else
    typedef enum logic [2:0] {IDLE = 3'd0, ENTRY = 3'd1, COOKING = 3'd2, PAUSED = 3'd3, DONE = 3'd4} state_t;
`endif
    state_t cur, nxt;
    logic [DW-1:0] dcount, dcount_d;
    logic [3:0] phase, phase_d, beep_cnt, beep_d, level_d, data_d;
    logic load_d, clr_d, digit_ok;

    assign digit_ok = key_valid && key_code <= 4'd9 && dcount < MAX_D && (cur == IDLE || cur == ENTRY);
    assign state = cur;
    // door term stays combinational so the magnetron drops with zero latency
    assign magnetron = closed_door && cur == COOKING && phase < power_level;
    assign lamp = !closed_door || cur == COOKING;

    always_comb begin
        nxt = cur;
        load_d = digit_ok;
        data_d = digit_ok ? key_code : 4'd0;
        clr_d = 1'b0;
        phase_d = phase;
        beep_d = beep_cnt;
        level_d = power_level;
        if ((cur == IDLE || cur == ENTRY) && power_key)
            level_d = power_level == PP ? 4'd1 : power_level + 4'd1;
        case (cur)
            IDLE: begin
                if (digit_ok) nxt = ENTRY;
`ifdef COOK_SEQUENCER_QUICK_START_EN
                else if (start && !stop && closed_door && dcount == '0) begin
                    nxt = QLOAD;
                    load_d = 1'b1;
                    data_d = 4'd3;
                end
`endif
            end
            ENTRY: begin
                if (stop) begin
                    nxt = IDLE;
                    clr_d = 1'b1;
                end else if (start && closed_door && !timer_zero) begin
                    nxt = COOKING;
                    phase_d = 4'd0;
                end
            end
            COOKING: begin
                if (tick_1hz) phase_d = phase == PP - 4'd1 ? 4'd0 : phase + 4'd1;
                if (timer_zero) begin
                    nxt = DONE;
                    beep_d = BEEP;
                end else if (!closed_door || stop) nxt = PAUSED;
            end
            PAUSED: begin
                if (stop) begin
                    nxt = IDLE;
                    clr_d = 1'b1;
                end else if (start && closed_door) nxt = COOKING;
            end
            DONE: begin
                if (!closed_door || stop || beep_cnt == 4'd0) nxt = IDLE;
                else if (tick_1hz) beep_d = beep_cnt - 4'd1;
            end
`ifdef COOK_SEQUENCER_QUICK_START_EN
            QLOAD: begin
                if (!closed_door) begin
                    nxt = IDLE;
                    clr_d = 1'b1;
                end else begin
                    nxt = COOKING;
                    load_d = 1'b1;
                    data_d = 4'd0;
                    phase_d = 4'd0;
                end
            end
`endif
            default: nxt = IDLE;
        endcase
        dcount_d = nxt == IDLE ? '0 : digit_ok ? dcount + DW'(1) : dcount;
    end

    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            cur <= IDLE;
            dcount <= '0;
            phase <= 4'd0;
            beep_cnt <= 4'd0;
            power_level <= PP;
            timer_load <= 1'b0;
            timer_data <= 4'd0;
            timer_clear <= 1'b0;
            timer_en <= 1'b0;
            beeper <= 1'b0;
        end else begin
            cur <= nxt;
            dcount <= dcount_d;
            phase <= phase_d;
            beep_cnt <= beep_d;
            power_level <= level_d;
            timer_load <= load_d;
            timer_data <= data_d;
            timer_clear <= clr_d;
            timer_en <= nxt == COOKING;
            beeper <= nxt == DONE;
        end
    end
endmodule

// File: tb/tb_cook_sequencer.sv
// tb_cook_sequencer: directed bench with a timer_load scoreboard for cook_sequencer.
module tb_cook_sequencer;
    logic clk = 1'b0, clear = 1'b1, tick_1hz = 1'b0, start = 1'b0, stop = 1'b0, closed_door = 1'b1;
    logic key_valid = 1'b0, power_key = 1'b0, timer_zero = 1'b0;
    logic [3:0] key_code = 4'd0;
    logic timer_load, timer_clear, timer_en, magnetron, beeper, lamp;
    logic [3:0] timer_data, power_level;
    logic [2:0] state;
    int checks = 0, errors = 0, clr_cnt = 0;
    logic [3:0] exp_q[$];

    cook_sequencer dut (
        .clk(clk), .clear(clear), .tick_1hz(tick_1hz), .start(start), .stop(stop),
        .closed_door(closed_door), .key_valid(key_valid), .key_code(key_code),
        .power_key(power_key), .timer_zero(timer_zero), .timer_load(timer_load),
        .timer_data(timer_data), .timer_clear(timer_clear), .timer_en(timer_en),
        .magnetron(magnetron), .beeper(beeper), .lamp(lamp), .power_level(power_level),
        .state(state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic key(input logic [3:0] k, input bit accepted);
        key_valid = 1'b1;
        key_code = k;
        if (accepted) exp_q.push_back(k);
        cyc(1);
        key_valid = 1'b0;
    endtask

    task automatic tick();
        tick_1hz = 1'b1;
        cyc(1);
        tick_1hz = 1'b0;
    endtask

    always @(negedge clk) begin
        if (timer_clear) clr_cnt++;
        if (timer_load) begin
            if (exp_q.size() == 0) chk("load_unexpected", 32'(timer_load), 0);
            else chk("load_data", 32'(timer_data), 32'(exp_q.pop_front()));
        end
    end

    initial begin
        #12;
        chk("rst_state", 32'(state), 0);
        chk("rst_power", 32'(power_level), 10);
        chk("rst_outs", {timer_load, timer_clear, timer_en, beeper, magnetron, lamp}, 0);
        chk("rst_data", 32'(timer_data), 0);
        closed_door = 1'b0;
        #1;
        chk("rst_lamp_door", 32'(lamp), 1);
        closed_door = 1'b1;
        clear = 1'b0;
        cyc(1);
        key(4'd1, 1);
        key(4'd12, 0);
        key(4'd3, 1);
        key(4'd0, 1);
        key(4'd5, 0);
        cyc(1);
        chk("entry_state", 32'(state), 1);
        power_key = 1'b1;
        cyc(5);
        power_key = 1'b0;
        chk("power_wrap", 32'(power_level), 5);
        start = 1'b1;
        cyc(1);
        start = 1'b0;
        chk("cook_state", 32'(state), 2);
        chk("cook_timer_en", 32'(timer_en), 1);
        for (int i = 0; i < 20; i++) begin
            chk($sformatf("duty_%0d", i), 32'(magnetron), 32'((i % 10) < 5));
            tick();
        end
        tick();
        tick();
        closed_door = 1'b0;
        #1;
        chk("door_mag_comb", 32'(magnetron), 0);
        chk("door_lamp", 32'(lamp), 1);
        chk("door_state_pre", 32'(state), 2);
        cyc(1);
        chk("paused_state", 32'(state), 3);
        chk("paused_timer_en", 32'(timer_en), 0);
        tick();
        closed_door = 1'b1;
        cyc(1);
        start = 1'b1;
        cyc(1);
        start = 1'b0;
        chk("resume_state", 32'(state), 2);
        chk("resume_phase2_mag", 32'(magnetron), 1);
        tick();
        tick();
        tick();
        chk("resume_phase5_mag", 32'(magnetron), 0);
        timer_zero = 1'b1;
        stop = 1'b1;
        cyc(1);
        timer_zero = 1'b0;
        stop = 1'b0;
        chk("done_state", 32'(state), 4);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("beep_%0d", i), 32'(beeper), 1);
            tick();
        end
        cyc(1);
        chk("beep_end_state", 32'(state), 0);
        chk("beep_end_beeper", 32'(beeper), 0);
        chk("no_clear_yet", 32'(clr_cnt), 0);
        key(4'd7, 1);
        start = 1'b1;
        stop = 1'b1;
        cyc(1);
        start = 1'b0;
        stop = 1'b0;
        chk("startstop_state", 32'(state), 0);
        cyc(2);
        chk("clear_pulses", 32'(clr_cnt), 1);
        key(4'd4, 1);
        key(4'd5, 1);
        key(4'd6, 1);
        key(4'd8, 0);
        cyc(1);
        timer_zero = 1'b1;
        start = 1'b1;
        cyc(1);
        timer_zero = 1'b0;
        chk("start_tz_ignored", 32'(state), 1);
        closed_door = 1'b0;
        cyc(1);
        start = 1'b0;
        chk("start_door_ignored", 32'(state), 1);
        closed_door = 1'b1;
        start = 1'b1;
        cyc(1);
        start = 1'b0;
        chk("cook2_state", 32'(state), 2);
        chk("cook2_mag", 32'(magnetron), 1);
        clear = 1'b1;
        #1;
        chk("clear_mag", 32'(magnetron), 0);
        chk("clear_state", 32'(state), 0);
        chk("clear_power", 32'(power_level), 10);
        clear = 1'b0;
        cyc(1);
        start = 1'b1;
`ifdef COOK_SEQUENCER_QUICK_START_EN
        exp_q.push_back(4'd3);
        exp_q.push_back(4'd0);
        cyc(1);
        start = 1'b0;
        chk("qload_state", 32'(state), 5);
        cyc(1);
        chk("qload_cook", 32'(state), 2);
        cyc(1);
`else
        cyc(1);
        start = 1'b0;
        cyc(2);
        chk("idle_start_ignored", 32'(state), 0);
`endif
        chk("scoreboard_empty", 32'(exp_q.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/cook_sequencer.md
# cook_sequencer

Cooking-cycle controller for the microwave. It sequences keypad digit entry into the countdown timer, runs the start/pause/resume/cancel state machine with the door interlock, and duty-cycles the magnetron according to a selectable power level. It drives a timed end-of-cycle beeper. It sits between the front-panel inputs and the timer/magnetron datapath, and replaces the bare magnetron on/off control logic.

## Interface
- BEEP_SECONDS, 3: beeper duration in DONE, in 1 Hz ticks (1..15).
- MAX_DIGITS, 3: maximum digits accepted per entry (1..3).
- POWER_PERIOD, 10: duty-cycle window length in ticks; power levels run 1..POWER_PERIOD.
- clk  in  1  system clock.
- clear  in  1  reset, asynchronous, active-high; also the panel clear button.
- tick_1hz  in  1  one-cycle pulse per second, synchronous to clk.
- start  in  1  one-cycle pulse, already synchronized and debounced.
- stop  in  1  one-cycle pulse.
- closed_door  in  1  level; 1 = door closed.
- key_valid  in  1  one-cycle pulse qualifying key_code.
- key_code  in  4  digit 0..9; values 10..15 are ignored.
- power_key  in  1  one-cycle pulse; advances the power level.
- timer_zero  in  1  timer reads 0:00.
- timer_load  out  1  one-cycle pulse that shifts timer_data into the timer.
- timer_data  out  4  digit presented with timer_load.
- timer_clear  out  1  one-cycle pulse that zeroes the timer.
- timer_en  out  1  enables timer countdown.
- magnetron  out  1  magnetron drive.
- beeper  out  1  buzzer.
- lamp  out  1  cavity lamp.
- power_level  out  4  current level, 1..POWER_PERIOD.
- state  out  3  encoded FSM state, for debug and display.

## Operation
- States: IDLE=0, ENTRY=1, COOKING=2, PAUSED=3, DONE=4, QLOAD=5 (QLOAD exists only with the macro).
- IDLE/ENTRY:
  - A valid digit (key_valid, key_code ≤ 9, digit count < MAX_DIGITS) registers timer_data=key_code and pulses timer_load. The digit count increments and the state becomes ENTRY.
  - Extra digits and invalid codes are ignored.
  - power_key: level+1; POWER_PERIOD wraps to 1.
- ENTRY:
  - start with closed_door=1 and timer_zero=0 → COOKING, and the phase counter is cleared.
  - start with the door open, or with timer_zero=1, is ignored.
  - stop → IDLE with a timer_clear pulse; the digit count clears.
- COOKING:
  - timer_en=1.
  - The phase counter increments on each tick_1hz, wrapping at POWER_PERIOD-1.
  - magnetron = closed_door AND (phase < power_level). The door term is combinational, as a safety gate.
  - Door open → PAUSED. stop → PAUSED. timer_zero → DONE.
  - Keys and power_key are ignored.
- PAUSED:
  - timer_en=0, magnetron=0, and the phase counter is held.
  - start with closed_door=1 → COOKING.
  - stop → IDLE with timer_clear.
- DONE:
  - beeper=1 and the tick counter is loaded with BEEP_SECONDS.
  - The counter decrements on each tick; at 0 → IDLE.
  - Door open or stop → IDLE immediately. Keys are ignored.
- lamp = ~closed_door OR (state==COOKING).
- Simultaneous events:
  - stop beats start.
  - timer_zero beats stop and door-open in COOKING; the state goes to DONE and magnetron is still gated by the door.
  - A door-open and start in the same cycle means no start.
- clear asserted: all registers take their reset values.
  - state=IDLE, power_level=POWER_PERIOD, and the digit count, phase and beep count are 0.
  - All pulse outputs are 0; timer_data=0; magnetron, beeper and timer_en are 0.
  - lamp still follows the door.

## Timing
- Every output is registered except magnetron and lamp, which are combinational gates of registered terms and closed_door.
- timer_load and timer_data are valid on the cycle after key_valid, for exactly 1 cycle.
- State transitions take effect on the clock edge that samples the event; the outputs of the new state are visible the next cycle.
- magnetron drops in the same cycle that closed_door falls, with zero clocks of latency.
- timer_clear is high for exactly 1 cycle, the cycle after the stop that causes it.
- The beep lasts BEEP_SECONDS whole tick intervals, ±1 tick of phase.
- Reset is asynchronous on assertion; release is synchronous to clk.

## Configuration
- COOK_SEQUENCER_QUICK_START_EN defined:
  - start in IDLE (digit count 0, door closed) → QLOAD.
  - QLOAD pulses timer_load with 3 and then with 0 on two consecutive cycles, then → COOKING. This programs 0:30.
  - Door open during QLOAD → IDLE with timer_clear.
- Undefined: start in IDLE is ignored, and the QLOAD state and its logic are absent.

## Test plan
- Reset, then keys 1,3,0: three timer_load pulses with data 1,3,0, each one cycle after its key_valid. A 4th key 5 produces no pulse. state=ENTRY.
- Entry, then start with the door closed and power_key pressed 5 times from 10 (wraps to 5): in COOKING, magnetron is high for ticks 0-4 and low for ticks 5-9 of each window, and timer_en=1.
- Door opened mid-COOKING: magnetron=0 in the same cycle, PAUSED next cycle, lamp=1. Door closed, then start → COOKING with the phase resumed.
- timer_zero in COOKING with stop in the same cycle: state=DONE, beeper=1 for 3 ticks, then IDLE with beeper=0.
- start and stop in the same cycle in ENTRY: state=IDLE and timer_clear pulses once. clear asserted mid-COOKING: magnetron=0 and state=IDLE without waiting for a clock edge.
- With COOK_SEQUENCER_QUICK_START_EN: start in IDLE gives load pulses 3 then 0 on consecutive cycles, then COOKING. Without the macro: no pulses and state stays IDLE.
